// File: rtl/ram_loader.sv
// Byte-stream RAM loader: SYNC, LEN, ADDR, LEN data bytes (+ CSUM) -> RAM write port.
// Define RAM_LOADER_CHECKSUM_EN to add the trailing checksum byte and the ERR path.
module ram_loader #(
   parameter logic [7:0] SYNC_BYTE     = 8'hA5,
   parameter logic       HOLD_ON_RESET = 1'b0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       in_valid,
   input  logic [7:0] in_data,
   output logic       in_ready,
   output logic       we,
   output logic [7:0] w_addr,
   output logic [7:0] w_data,
   output logic       cpu_hold,
   output logic       busy,
   output logic       done,
   output logic       error
);

   typedef enum logic [2:0] {IDLE, LEN, ADDR, DATA, CSUM, DONE, ERR} state_t;

   state_t     state;
   logic [7:0] cnt;    // data bytes remaining minus one; LEN=0 loads 8'hFF -> 256 bytes
   logic [7:0] addr;
   logic       acc;
`ifdef RAM_LOADER_CHECKSUM_EN
   logic [7:0] sum;
`endif

   assign acc = in_valid && in_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         in_ready <= 1'b0;
         we       <= 1'b0;
         w_addr   <= 8'h00;
         w_data   <= 8'h00;
         cpu_hold <= HOLD_ON_RESET;
         busy     <= 1'b0;
         done     <= 1'b0;
         error    <= 1'b0;
         cnt      <= 8'h00;
         addr     <= 8'h00;
`ifdef RAM_LOADER_CHECKSUM_EN
         sum      <= 8'h00;
`endif
      end else begin
         we       <= 1'b0;
         done     <= 1'b0;
         in_ready <= 1'b1;
         case (state)
            IDLE, ERR: begin
               if (acc && in_data == SYNC_BYTE) begin
                  state    <= LEN;
                  busy     <= 1'b1;
                  cpu_hold <= 1'b1;
                  error    <= 1'b0;
               end
            end
            LEN: begin
               if (acc) begin
                  cnt   <= 8'(in_data - 8'd1);
                  state <= ADDR;
`ifdef RAM_LOADER_CHECKSUM_EN
                  sum   <= in_data;
`endif
               end
            end
            ADDR: begin
               if (acc) begin
                  addr  <= in_data;
                  state <= DATA;
`ifdef RAM_LOADER_CHECKSUM_EN
                  sum   <= 8'(sum + in_data);
`endif
               end
            end
            DATA: begin
               if (acc) begin
                  we     <= 1'b1;
                  w_addr <= addr;
                  w_data <= in_data;
                  addr   <= 8'(addr + 8'd1);
                  cnt    <= 8'(cnt - 8'd1);
`ifdef RAM_LOADER_CHECKSUM_EN
                  sum    <= 8'(sum + in_data);
                  if (cnt == 8'h00) state <= CSUM;
`else
                  if (cnt == 8'h00) begin
                     state    <= DONE;
                     busy     <= 1'b0;
                     done     <= 1'b1;
                     cpu_hold <= 1'b0;
                     in_ready <= 1'b0;
                  end
`endif
               end
            end
`ifdef RAM_LOADER_CHECKSUM_EN
            CSUM: begin
               if (acc) begin
                  busy <= 1'b0;
                  if (8'(sum + in_data) == 8'h00) begin
                     state    <= DONE;
                     done     <= 1'b1;
                     cpu_hold <= 1'b0;
                     in_ready <= 1'b0;
                  end else begin
                     state <= ERR;
                     error <= 1'b1;
                  end
               end
            end
`endif
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ram_loader.sv
// Scoreboard bench for ram_loader: expected writes are queued as frames are issued, a monitor pops them on we.
module tb_ram_loader;

   localparam logic [7:0] SYNC = 8'hA5;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic [7:0] in_data;
   logic       in_ready, we, cpu_hold, busy, done, error;
   logic [7:0] w_addr, w_data;

   int vectors = 0;
   int miscompares = 0;
   logic [15:0] wq[$];
   logic [7:0]  pl[$];

   ram_loader #(.SYNC_BYTE(SYNC), .HOLD_ON_RESET(1'b0)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .we(we), .w_addr(w_addr), .w_data(w_data), .cpu_hold(cpu_hold), .busy(busy),
      .done(done), .error(error)
   );

   always #5 clk = ~clk;

   // write monitor
   always @(negedge clk) begin
      if (we) begin
         logic [15:0] exp;
         vectors++;
         if (wq.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_write: got %h:%h expected no write", w_addr, w_data);
         end else begin
            exp = wq.pop_front();
            if ({w_addr, w_data} !== exp) begin
               miscompares++;
               $display("FAIL write: got %h:%h expected %h:%h", w_addr, w_data, exp[15:8], exp[7:0]);
            end
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // called at a negedge; returns at the negedge after the byte is accepted
   task automatic send(input logic [7:0] b);
      logic rdy;
      int   n = 0;
      in_valid = 1'b1;
      in_data  = b;
      forever begin
         rdy = in_ready;
         @(posedge clk);
         if (rdy) break;
         n++;
         if (n > 20) begin
            miscompares++;
            vectors++;
            $display("FAIL send_timeout: got in_ready=0 expected 1 within 20 cycles");
            break;
         end
         @(negedge clk);
      end
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic chk_reset_vals();
      chk("rst_we", we, 0);
      chk("rst_w_addr", w_addr, 0);
      chk("rst_w_data", w_data, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_error", error, 0);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_cpu_hold", cpu_hold, 0);
   endtask

   // abort_after>0: return right after that many data bytes; bad_csum corrupts the checksum byte
   task automatic run_frame(input logic [7:0] len, input logic [7:0] addr,
                            input int abort_after, input bit bad_csum);
      int n = (len == 8'h00) ? 256 : int'(len);
      int nw = (abort_after > 0) ? abort_after : n;
      logic [7:0] s = 8'(len + addr);
      for (int i = 0; i < nw; i++) wq.push_back({8'(addr + i), pl[i]});
      send(SYNC);
      chk("sync_busy", busy, 1);
      chk("sync_cpu_hold", cpu_hold, 1);
      chk("sync_error", error, 0);
      send(len);
      send(addr);
      chk("hdr_busy", busy, 1);
      for (int i = 0; i < n; i++) begin
         s = 8'(s + pl[i]);
         send(pl[i]);
         if (abort_after == i + 1) return;
`ifdef RAM_LOADER_CHECKSUM_EN
         chk("data_busy", busy, 1);
`else
         if (i != n - 1) chk("data_busy", busy, 1);
`endif
      end
`ifdef RAM_LOADER_CHECKSUM_EN
      send(bad_csum ? 8'(8'h00 - s + 8'd1) : 8'(8'h00 - s));
`endif
      if (!bad_csum) begin
         chk("end_done", done, 1);
         chk("end_cpu_hold", cpu_hold, 0);
         chk("end_busy", busy, 0);
         chk("end_in_ready", in_ready, 0);
         @(negedge clk);
         chk("post_done", done, 0);
         chk("post_in_ready", in_ready, 1);
      end else begin
         chk("err_error", error, 1);
         chk("err_cpu_hold", cpu_hold, 1);
         chk("err_busy", busy, 0);
         chk("err_done", done, 0);
         @(negedge clk);
      end
      @(negedge clk);
      chk("writes_left", wq.size(), 0);
   endtask

   initial begin
      rst = 1'b1;
      in_valid = 1'b0;
      in_data = 8'h00;
      repeat (2) @(negedge clk);
      chk_reset_vals();
      rst = 1'b0;
      @(negedge clk);

      // basic 3-byte frame
      pl = '{8'h11, 8'h22, 8'h33};
      run_frame(8'h03, 8'h10, 0, 1'b0);

      // idle garbage is discarded
      send(8'h00);
      send(8'hFF);
      chk("garbage_busy", busy, 0);
      chk("garbage_cpu_hold", cpu_hold, 0);
      pl = '{8'h5A};
      run_frame(8'h01, 8'h20, 0, 1'b0);

      // address wrap
      pl = '{8'h01, 8'h02};
      run_frame(8'h02, 8'hFF, 0, 1'b0);

`ifdef RAM_LOADER_CHECKSUM_EN
      pl = '{8'hAA};
      run_frame(8'h01, 8'h00, 0, 1'b1);
      chk("err_sticky", error, 1);
      pl = '{8'h77};
      run_frame(8'h01, 8'h30, 0, 1'b0);
      chk("err_cleared", error, 0);
`endif

      // reset mid-frame after the second data byte
      pl = '{8'hD0, 8'hD1, 8'hD2, 8'hD3, 8'hD4, 8'hD5, 8'hD6, 8'hD7};
      run_frame(8'h08, 8'h40, 2, 1'b0);
      rst = 1'b1;
      @(negedge clk);
      chk_reset_vals();
      repeat (3) @(negedge clk);
      chk("abort_writes_left", wq.size(), 0);
      rst = 1'b0;
      @(negedge clk);
      pl = '{8'hE1, 8'hE2};
      run_frame(8'h02, 8'h50, 0, 1'b0);

      // LEN=0 -> 256 bytes covering every address
      pl.delete();
      for (int i = 0; i < 256; i++) pl.push_back(8'(i ^ 8'h5C));
      run_frame(8'h00, 8'h80, 0, 1'b0);

      repeat (3) @(negedge clk);
      chk("final_writes_left", wq.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
